// File: rtl/memristor_pulse_seq_pkg.sv
// Shared op codes, sequencer states and drive-level helpers for the memristor
// pulse sequencer.
package memristor_pulse_seq_pkg;

   localparam int OP_W = 2;
   localparam int CH_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_SET   = 2'd0,
      OP_RESET = 2'd1,
      OP_READ  = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_GAP,
      ST_DONE
   } state_e;

   // DIGITALIN level during the pulse itself
   function automatic logic pulse_level(op_e op);
      return op != OP_RESET;
   endfunction

   // DIGITALIN level while SEL is guarded around the pulse
   function automatic logic idle_level(op_e op);
      return op == OP_RESET;
   endfunction

endpackage

// File: rtl/memristor_pulse_seq_if.sv
// Command channel into the sequencer: valid/ready handshake plus command fields.
interface memristor_pulse_seq_if #(
   parameter int WIDTH_W = 16,
   parameter int COUNT_W = 8
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [1:0]         cmd_ch;
   logic [WIDTH_W-1:0] cmd_width;
   logic [COUNT_W-1:0] cmd_count;

   modport master (output cmd_valid, cmd_op, cmd_ch, cmd_width, cmd_count,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, cmd_op, cmd_ch, cmd_width, cmd_count,
                   output cmd_ready);
endinterface

// File: rtl/memristor_pulse_timer.sv
// Loadable down-counter shared by every timed phase; stops at zero.
module memristor_pulse_timer #(
   parameter int W = 16
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic [W-1:0] o_value,
   output logic         o_zero
);

   logic [W-1:0] r_value;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n)
         r_value <= '0;
      else if (i_load)
         r_value <= i_load_val;
      else if (r_value != '0)
         r_value <= r_value - W'(1);
   end

   assign o_value = r_value;
   assign o_zero  = (r_value == '0);

endmodule

// File: rtl/memristor_pulse_seq.sv
// Sequencer turning SET/RESET/READ commands into guarded SEL/DIGITALIN pulse
// trains on one memristor channel.
module memristor_pulse_seq
   import memristor_pulse_seq_pkg::*;
#(
   parameter int N_CH      = 3,
   parameter int WIDTH_W   = 16,
   parameter int COUNT_W   = 8,
   parameter int SETUP_CYC = 2,
   parameter int HOLD_CYC  = 2,
   parameter int GAP_CYC   = 4
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n,
   memristor_pulse_seq_if.slave cmd_if,
   input  logic                 abort,
   output logic [N_CH-1:0]      sel_o,
   output logic [N_CH-1:0]      din_o,
   output logic                 rd_strobe,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [COUNT_W-1:0]   pulse_cnt
);

   state_e             r_state, w_state_nxt;
   op_e                r_op, w_op_nxt;
   logic [CH_W-1:0]    r_ch, w_ch_nxt;
   logic [WIDTH_W-1:0] r_len;
   logic [COUNT_W-1:0] r_count, r_pulse_cnt;
   logic               r_err_pend, w_err_nxt;
   logic               r_sel_dummy_unused;
   logic [N_CH-1:0]    r_sel, r_din, w_onehot;
   logic               r_rd, r_busy, r_done, r_err, r_ready;

   logic               w_load, w_cnt_inc, w_tmr_zero, w_accept, w_bad;
   logic               w_active, w_level, w_tmr_last_nxt;
   logic [WIDTH_W-1:0] w_load_val, w_tmr_val;

   memristor_pulse_timer #(.W(WIDTH_W)) u_timer (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_n   (wb_rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_value    (w_tmr_val),
      .o_zero     (w_tmr_zero)
   );

   assign w_accept = cmd_if.cmd_valid && r_ready;
   assign w_bad    = (cmd_if.cmd_op == OP_RSVD) || (int'(cmd_if.cmd_ch) >= N_CH);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_cnt_inc   = 1'b0;
      w_err_nxt   = r_err_pend;
      unique case (r_state)
         ST_IDLE: if (w_accept) begin
            w_err_nxt = w_bad;
            if (w_bad) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_SETUP;
               w_load      = 1'b1;
               w_load_val  = WIDTH_W'(SETUP_CYC - 1);
            end
         end
         ST_SETUP: if (abort) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = 1'b1;
         end else if (w_tmr_zero) begin
            w_state_nxt = ST_PULSE;
            w_load      = 1'b1;
            w_load_val  = r_len;
         end
         // An aborted pulse still gets its hold guard but is not counted
         ST_PULSE: if (abort || w_tmr_zero) begin
            w_state_nxt = ST_HOLD;
            w_load      = 1'b1;
            w_load_val  = WIDTH_W'(HOLD_CYC - 1);
            w_cnt_inc   = !abort;
            if (abort) w_err_nxt = 1'b1;
         end
         ST_HOLD: begin
            if (abort) w_err_nxt = 1'b1;
            if (w_tmr_zero) begin
               if (w_err_nxt || r_pulse_cnt >= r_count) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_GAP;
                  w_load      = 1'b1;
                  w_load_val  = WIDTH_W'(GAP_CYC - 1);
               end
            end
         end
         ST_GAP: if (abort) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = 1'b1;
         end else if (w_tmr_zero) begin
            w_state_nxt = ST_SETUP;
            w_load      = 1'b1;
            w_load_val  = WIDTH_W'(SETUP_CYC - 1);
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next-state view so pins move with the state
   assign w_op_nxt = w_accept ? op_e'(cmd_if.cmd_op) : r_op;
   assign w_ch_nxt = w_accept ? cmd_if.cmd_ch : r_ch;
   assign w_onehot = N_CH'(1) << w_ch_nxt;
   assign w_active = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_PULSE) ||
                     (w_state_nxt == ST_HOLD);
   assign w_level  = (w_state_nxt == ST_PULSE) ? pulse_level(w_op_nxt)
                                               : idle_level(w_op_nxt);
   assign w_tmr_last_nxt = w_load ? (w_load_val == '0) : (w_tmr_val <= WIDTH_W'(1));
   assign r_sel_dummy_unused = 1'b0;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_SET;
         r_ch        <= '0;
         r_len       <= '0;
         r_count     <= '0;
         r_pulse_cnt <= '0;
         r_err_pend  <= 1'b0;
         r_sel       <= '0;
         r_din       <= '0;
         r_rd        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_ready     <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register here samples the pre-edge values.
         r_state    <= w_state_nxt;
         r_op       <= w_op_nxt;
         r_ch       <= w_ch_nxt;
         r_err_pend <= w_err_nxt;
         if (w_accept) begin
            r_len       <= (cmd_if.cmd_width == '0) ? '0 : cmd_if.cmd_width - WIDTH_W'(1);
            r_count     <= (cmd_if.cmd_count == '0) ? COUNT_W'(1) : cmd_if.cmd_count;
            r_pulse_cnt <= '0;
         end else if (w_cnt_inc && r_pulse_cnt != '1) begin
            r_pulse_cnt <= r_pulse_cnt + COUNT_W'(1);
         end
         r_sel   <= w_active ? w_onehot : '0;
         r_din   <= (w_active && w_level) ? w_onehot : '0;
         r_rd    <= (w_state_nxt == ST_PULSE) && (w_op_nxt == OP_READ) && w_tmr_last_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= (w_state_nxt == ST_DONE);
         r_err   <= (w_state_nxt == ST_DONE) && w_err_nxt;
         r_ready <= (w_state_nxt == ST_IDLE);
      end
   end

   assign cmd_if.cmd_ready = r_ready;
   assign sel_o     = r_sel;
   assign din_o     = r_din;
   assign rd_strobe = r_rd;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_memristor_pulse_seq.sv
// Self-checking bench: directed and random commands against a per-cycle
// timeline model built from the pulse-train rules.
module tb_memristor_pulse_seq;

   localparam int N_CH      = 3;
   localparam int WIDTH_W   = 16;
   localparam int COUNT_W   = 8;
   localparam int SETUP_CYC = 2;
   localparam int HOLD_CYC  = 2;
   localparam int GAP_CYC   = 4;

   typedef enum int {K_IDLE, K_SETUP, K_PULSE, K_HOLD, K_GAP, K_DONE} kind_e;

   logic               wb_clk_i = 1'b0;
   logic               wb_rst_n = 1'b0;
   logic               abort    = 1'b0;
   logic [N_CH-1:0]    sel_o, din_o;
   logic               rd_strobe, busy, done, err;
   logic [COUNT_W-1:0] pulse_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   memristor_pulse_seq_if #(.WIDTH_W(WIDTH_W), .COUNT_W(COUNT_W)) cmd_if ();

   memristor_pulse_seq #(
      .N_CH(N_CH), .WIDTH_W(WIDTH_W), .COUNT_W(COUNT_W),
      .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_n  (wb_rst_n),
      .cmd_if    (cmd_if),
      .abort     (abort),
      .sel_o     (sel_o),
      .din_o     (din_o),
      .rd_strobe (rd_strobe),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .pulse_cnt (pulse_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {ready, busy, done, err, rd_strobe, sel[2:0], din[2:0]}
   function automatic logic [10:0] out_vec();
      return {cmd_if.cmd_ready, busy, done, err, rd_strobe, sel_o, din_o};
   endfunction

   // Builds the expected timeline of the command, then steps the DUT through it
   // one cycle at a time; a = cycle during which abort is held (0 = never).
   task automatic run_cmd(input logic [1:0] op, input logic [1:0] ch, input int w,
                          input int n, input int a, input bit junk, input string name);
      kind_e      tl[0:299];
      int         pend[1:8];
      int         wl, nl, len, idx, h, exp_cnt;
      bit         bad, aborted, act, lvl;
      logic [2:0] oh;
      logic       pl, il;
      logic [10:0] ev;
      kind_e      k;

      bad     = (op == 2'd3) || (int'(ch) >= N_CH);
      wl      = (w == 0) ? 1 : w;
      nl      = (n == 0) ? 1 : n;
      aborted = 1'b0;
      exp_cnt = 0;
      if (bad) begin
         tl[1] = K_DONE;
         len   = 1;
      end else begin
         idx = 1;
         for (int p = 1; p <= nl; p++) begin
            for (int i = 0; i < SETUP_CYC; i++) tl[idx++] = K_SETUP;
            for (int i = 0; i < wl; i++)        tl[idx++] = K_PULSE;
            pend[p] = idx - 1;
            for (int i = 0; i < HOLD_CYC; i++)  tl[idx++] = K_HOLD;
            if (p < nl) for (int i = 0; i < GAP_CYC; i++) tl[idx++] = K_GAP;
         end
         tl[idx] = K_DONE;
         len     = idx;
         exp_cnt = nl;
         if (a > 0 && a < len) begin
            aborted = 1'b1;
            exp_cnt = 0;
            for (int p = 1; p <= nl; p++) if (pend[p] < a) exp_cnt++;
            case (tl[a])
               K_SETUP, K_GAP: begin
                  tl[a+1] = K_DONE;
                  len     = a + 1;
               end
               K_PULSE: begin
                  for (int i = 1; i <= HOLD_CYC; i++) tl[a+i] = K_HOLD;
                  tl[a+HOLD_CYC+1] = K_DONE;
                  len              = a + HOLD_CYC + 1;
               end
               K_HOLD: begin
                  h = a;
                  while (tl[h+1] == K_HOLD) h++;
                  tl[h+1] = K_DONE;
                  len     = h + 1;
               end
               default: ;
            endcase
         end
      end
      tl[len+1] = K_IDLE;
      tl[len+2] = K_IDLE;

      oh = 3'b001 << ch;
      pl = (op != 2'd1);
      il = (op == 2'd1);

      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_ch    = ch;
      cmd_if.cmd_width = WIDTH_W'(w);
      cmd_if.cmd_count = COUNT_W'(n);
      @(posedge wb_clk_i); #1;
      for (int c = 1; c <= len + 1; c++) begin
         k   = tl[c];
         act = (k == K_SETUP) || (k == K_PULSE) || (k == K_HOLD);
         lvl = (k == K_PULSE) ? pl : il;
         ev  = {k == K_IDLE, k != K_IDLE, k == K_DONE,
                (k == K_DONE) && (bad || aborted),
                (k == K_PULSE) && (tl[c+1] != K_PULSE) && (op == 2'd2),
                act ? oh : 3'b000, (act && lvl) ? oh : 3'b000};
         check($sformatf("%s cyc%0d", name, c), 32'(out_vec()), 32'(ev));
         abort = (c == a);
         if (junk && c <= len) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_op    = 2'($urandom_range(0, 3));
            cmd_if.cmd_ch    = 2'($urandom_range(0, 3));
            cmd_if.cmd_width = WIDTH_W'($urandom_range(0, 20));
            cmd_if.cmd_count = COUNT_W'($urandom_range(0, 5));
         end else begin
            cmd_if.cmd_valid = 1'b0;
         end
         @(posedge wb_clk_i); #1;
      end
      abort            = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      check($sformatf("%s pulse_cnt", name), 32'(pulse_cnt), 32'(exp_cnt));
   endtask

   initial begin
      logic [1:0] r_op, r_ch;
      int         r_w, r_n, r_a;

      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = '0;
      cmd_if.cmd_ch    = '0;
      cmd_if.cmd_width = '0;
      cmd_if.cmd_count = '0;

      repeat (2) @(posedge wb_clk_i);
      #1;
      check("reset outputs", 32'(out_vec()), 32'(11'b100_0000_0000));
      check("reset pulse_cnt", 32'(pulse_cnt), 32'd0);
      wb_rst_n = 1'b1;
      @(posedge wb_clk_i); #1;

      run_cmd(2'd0, 2'd0, 5, 1, 0, 1'b0, "set_ch0_w5");
      run_cmd(2'd1, 2'd2, 3, 2, 0, 1'b1, "reset_ch2_w3_n2");
      run_cmd(2'd2, 2'd1, 4, 1, 0, 1'b0, "read_ch1_w4");
      run_cmd(2'd3, 2'd0, 5, 1, 0, 1'b0, "bad_op");
      run_cmd(2'd0, 2'd3, 5, 1, 0, 1'b0, "bad_ch");
      run_cmd(2'd0, 2'd0, 10, 1, 4, 1'b0, "abort_pulse");
      run_cmd(2'd0, 2'd1, 0, 0, 0, 1'b0, "zero_w_n");
      run_cmd(2'd1, 2'd0, 2, 3, 2, 1'b0, "abort_setup");
      run_cmd(2'd0, 2'd2, 2, 2, 8, 1'b0, "abort_gap");
      run_cmd(2'd1, 2'd1, 2, 2, 5, 1'b0, "abort_hold");
      run_cmd(2'd2, 2'd2, 1, 3, 0, 1'b1, "read_w1_n3");

      for (int i = 0; i < 25; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_ch = 2'($urandom_range(0, 3));
         r_w  = $urandom_range(0, 6);
         r_n  = $urandom_range(0, 3);
         r_a  = 0;
         if (r_op != 2'd2 && $urandom_range(0, 1) == 1) r_a = $urandom_range(1, 40);
         run_cmd(r_op, r_ch, r_w, r_n, r_a, 1'($urandom_range(0, 1)),
                 $sformatf("rand%0d", i));
      end

      // Reset in the middle of a pulse must clear the pins without a clock edge
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 2'd0;
      cmd_if.cmd_ch    = 2'd1;
      cmd_if.cmd_width = WIDTH_W'(10);
      cmd_if.cmd_count = COUNT_W'(1);
      @(posedge wb_clk_i); #1;
      cmd_if.cmd_valid = 1'b0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      check("midreset pre din", 32'(din_o), 32'(3'b010));
      #2 wb_rst_n = 1'b0;
      #1;
      check("midreset outputs", 32'(out_vec()), 32'(11'b100_0000_0000));
      check("midreset pulse_cnt", 32'(pulse_cnt), 32'd0);
      @(posedge wb_clk_i); #1;
      wb_rst_n = 1'b1;
      @(posedge wb_clk_i); #1;
      run_cmd(2'd1, 2'd0, 3, 1, 0, 1'b1, "after_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
